pqs_vga_timing: RTL and testbench

//  Video timing generator clocked by the 108 MHz PLL output. It is the stage directly downstream of the PLL.

---
 rtl/pqs_vga_timing.sv | 186 ++++++++++++++++++
 tb/tb_pqs_vga_timing.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pqs_vga_timing.sv
// rtl/pqs_vga_timing.sv - 1280x1024@60 raster timing generator gated by a qualified PLL lock
// Optional colour-bar test pattern: define PQS_VGA_TESTPAT_EN.
module pqs_vga_timing #(
    parameter int   H_ACTIVE    = 1280,
    parameter int   H_FP        = 48,
    parameter int   H_SYNC      = 112,
    parameter int   H_BP        = 248,
    parameter int   V_ACTIVE    = 1024,
    parameter int   V_FP        = 1,
    parameter int   V_SYNC      = 3,
    parameter int   V_BP        = 38,
    parameter logic HS_POL      = 1'b1,
    parameter logic VS_POL      = 1'b1,
    parameter int   LOCK_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pll_locked,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        line_start,
    output logic        frame_start,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int LCW     = $clog2(LOCK_CYCLES);

    localparam logic [10:0] H_ACT_C   = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS_C    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE_C    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST_C  = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_ACT_C   = 11'(V_ACTIVE);
    localparam logic [10:0] V_SS_C    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE_C    = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST_C  = 11'(V_TOTAL - 1);
    localparam logic [LCW-1:0] LOCK_LAST_C = LCW'(LOCK_CYCLES - 1);

    typedef enum logic {WAIT_LOCK, RUN} state_t;

    state_t          state_q, state_d;
    logic            lk_meta_q, lk_s_q;
    logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
    logic [10:0]     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;

    logic            video_on_q, video_on_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic            de_q, de_d, line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic [10:0]     x_q, x_d, y_q, y_d;
    logic            run_ok;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (!lk_s_q) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST_C) begin
                    state_d    = RUN;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            RUN: begin
                lock_cnt_d = '0;
                // Losing lock abandons the frame immediately; no attempt to finish it.
                if (!lk_s_q) begin
                    state_d = WAIT_LOCK;
                    h_cnt_d = '0;
                    v_cnt_d = '0;
                end else if (h_cnt_q == H_LAST_C) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == V_LAST_C) ? 11'd0 : v_cnt_q + 11'd1;
                end else begin
                    h_cnt_d = h_cnt_q + 11'd1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // Gating with lk_s_q idles the outputs on the same edge the FSM leaves RUN.
    assign run_ok = (state_q == RUN) && lk_s_q;

    always_comb begin
        video_on_d    = run_ok;
        x_d           = run_ok ? h_cnt_q : 11'd0;
        y_d           = run_ok ? v_cnt_q : 11'd0;
        de_d          = run_ok && (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        hsync_d       = (run_ok && (h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C)) ? HS_POL : ~HS_POL;
        vsync_d       = (run_ok && (v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C)) ? VS_POL : ~VS_POL;
        line_start_d  = run_ok && (h_cnt_q == 11'd0);
        frame_start_d = run_ok && (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lk_meta_q     <= 1'b0;
            lk_s_q        <= 1'b0;
            state_q       <= WAIT_LOCK;
            lock_cnt_q    <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            video_on_q    <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            lk_meta_q     <= pll_locked;
            lk_s_q        <= lk_meta_q;
            state_q       <= state_d;
            lock_cnt_q    <= lock_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            video_on_q    <= video_on_d;
            x_q           <= x_d;
            y_q           <= y_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign video_on    = video_on_q;
    assign x           = x_q;
    assign y           = y_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef PQS_VGA_TESTPAT_EN
    localparam logic [10:0] BAR_W_C = 11'(H_ACTIVE / 8);

    logic [2:0] bar;
    logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;

    // Bar index bits map directly onto channels: b alternates, r pairs, g halves.
    always_comb begin
        bar = 3'(h_cnt_q / BAR_W_C);
        r_d = (de_d && !bar[1]) ? 8'hFF : 8'h00;
        g_d = (de_d && !bar[2]) ? 8'hFF : 8'h00;
        b_d = (de_d && !bar[0]) ? 8'hFF : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 8'h00;
            g_q <= 8'h00;
            b_q <= 8'h00;
        end else begin
            r_q <= r_d;
            g_q <= g_d;
            b_q <= b_d;
        end
    end

    assign vga_r = r_q;
    assign vga_g = g_q;
    assign vga_b = b_q;
`else
    assign vga_r = 8'h00;
    assign vga_g = 8'h00;
    assign vga_b = 8'h00;
`endif

endmodule

// File: tb/tb_pqs_vga_timing.sv
// tb/tb_pqs_vga_timing.sv - scoreboard bench for pqs_vga_timing on a reduced raster
module tb_pqs_vga_timing;

    localparam int HA = 64, HFP = 4, HSW = 8, HBP = 12;
    localparam int VA = 20, VFP = 1, VSW = 3, VBP = 4;
    localparam int LK = 16;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;

    logic        clk = 1'b0;
    logic        rst, pll_locked;
    logic        video_on, hsync, vsync, de, line_start, frame_start;
    logic [10:0] x, y;
    logic [7:0]  vga_r, vga_g, vga_b;

    typedef struct packed {
        logic        video_on;
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [10:0] x;
        logic [10:0] y;
        logic        line_start;
        logic        frame_start;
        logic [23:0] rgb;
    } out_t;

    out_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          tnow  = 0;
    int          ls_cnt, de_cnt;
    logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    pqs_vga_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_CYCLES(LK)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .video_on(video_on), .hsync(hsync), .vsync(vsync), .de(de),
        .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    function automatic out_t idle_out();
        out_t o;
        o = '0;
        return o;
    endfunction

    function automatic out_t act_out(int t);
        out_t o;
        int   px, py;
        px = t % HT;
        py = (t / HT) % VT;
        o.video_on    = 1'b1;
        o.x           = 11'(px);
        o.y           = 11'(py);
        o.de          = (px < HA) && (py < VA);
        o.hsync       = (px >= HA + HFP) && (px < HA + HFP + HSW);
        o.vsync       = (py >= VA + VFP) && (py < VA + VFP + VSW);
        o.line_start  = (px == 0);
        o.frame_start = (px == 0) && (py == 0);
`ifdef PQS_VGA_TESTPAT_EN
        o.rgb         = o.de ? bars[px / (HA / 8)] : 24'h000000;
`else
        o.rgb         = 24'h000000;
`endif
        return o;
    endfunction

    task automatic step(input string tag, input out_t e);
        out_t obs, ex;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs.video_on    = video_on;
        obs.hsync       = hsync;
        obs.vsync       = vsync;
        obs.de          = de;
        obs.x           = x;
        obs.y           = y;
        obs.line_start  = line_start;
        obs.frame_start = frame_start;
        obs.rgb         = {vga_r, vga_g, vga_b};
        ls_cnt += int'(line_start);
        de_cnt += int'(de);
        ex = exp_q.pop_front();
        n_cmp++;
        assert (obs === ex) else begin
            n_err++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, ex);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int ex);
        n_cmp++;
        assert (obs === ex) else begin
            n_err++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, ex);
        end
    endtask

    task automatic run_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, idle_out());
    endtask

    task automatic run_active(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(tag, act_out(tnow));
            tnow++;
        end
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b1;
        ls_cnt     = 0;
        de_cnt     = 0;

        run_idle("t1_reset", 5);

        rst = 1'b0;
        run_idle("t2_qualify", LK + 2);

        tnow   = 0;
        ls_cnt = 0;
        de_cnt = 0;
        run_active("t3_frame", HT * VT);
        check_int("t3_line_starts", ls_cnt, VT);
        check_int("t3_de_clocks", de_cnt, HA * VA);
        run_active("t3_wrap", HT);

        run_active("t4_to_mid", 9 * HT + 5);
        pll_locked = 1'b0;
        step("t4_glitch0", act_out(tnow));
        tnow++;
        pll_locked = 1'b1;
        step("t4_glitch1", act_out(tnow));
        run_idle("t4_requalify", LK + 1);
        tnow = 0;
        run_active("t4_restart", 7 * HT + 40);

        rst = 1'b1;
        run_idle("t5_reset_edge", 1);
        rst = 1'b0;
        run_idle("t5_requalify", LK + 2);
        tnow = 0;
        run_active("t5_restart", 2 * HT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
